// File: rtl/pipe_sched_pkg.sv
// rtl/pipe_sched_pkg.sv - shared state encoding for the pipeline scheduler
package pipe_sched_pkg;

   localparam int SCHED_ST_BIT = 2;

   typedef enum logic [SCHED_ST_BIT-1:0] {
      SCHED_RUN   = 2'd0,
      SCHED_DRAIN = 2'd1,
      SCHED_HALT  = 2'd2
   } sched_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter for debug statistics
// Ports: clk, rst (async, active-high), en (step enable), inc (count request),
//        cnt (current value, sticks at all-ones).
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (en && inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pipe_sched.sv
// rtl/pipe_sched.sv - 5-stage pipeline stall/flush/halt scheduler
// Ports: clk, rst (async, active-high), en (single-step enable),
//        id_* (ID source operands), ex_* (EX destination, load, redirect, halt),
//        resume (debug resume pulse);
//        pc_en, if_id_en, if_id_flush, id_ex_flush (stage controls),
//        halted, stall_cnt, flush_cnt (debug status).
module pipe_sched
   import pipe_sched_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_rf_we,
   input  logic [4:0]       ex_req_w,
   input  logic             ex_is_load,
   input  logic             ex_redirect,
   input  logic             ex_halt,
   input  logic             resume,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   sched_state_t  state, state_nx;
   logic [DW-1:0] drain_cnt, drain_nx;
   logic          halted_nx;
   logic          hazard;
   logic          pc_en_c, if_id_en_c, if_id_flush_c, id_ex_flush_c;
   logic          stall_inc, flush_inc;

   // $0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign hazard = ex_is_load & ex_rf_we & (ex_req_w != 5'd0) &
                   ((id_uses_rs & (id_rs == ex_req_w)) |
                    (id_uses_rt & (id_rt == ex_req_w)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SCHED_RUN;
         drain_cnt <= '0;
         halted    <= 1'b0;
      end else if (en) begin
         state     <= state_nx;
         drain_cnt <= drain_nx;
         halted    <= halted_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      drain_nx      = drain_cnt;
      halted_nx     = halted;
      pc_en_c       = 1'b0;
      if_id_en_c    = 1'b0;
      if_id_flush_c = 1'b0;
      id_ex_flush_c = 1'b0;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;
      case (state)
         SCHED_RUN: begin
            if (ex_halt) begin
               // Squash younger instructions; EX/MEM/WB retire during DRAIN.
               if_id_en_c    = 1'b1;
               if_id_flush_c = 1'b1;
               id_ex_flush_c = 1'b1;
               state_nx      = SCHED_DRAIN;
               drain_nx      = DW'(DRAIN_CYCLES - 1);
            end else if (ex_redirect) begin
               pc_en_c       = 1'b1;
               if_id_en_c    = 1'b1;
               if_id_flush_c = 1'b1;
               id_ex_flush_c = 1'b1;
               flush_inc     = 1'b1;
            end else if (hazard) begin
               // Hold PC and IF/ID, insert one bubble while the load reaches MEM.
               id_ex_flush_c = 1'b1;
               stall_inc     = 1'b1;
            end else begin
               pc_en_c    = 1'b1;
               if_id_en_c = 1'b1;
            end
         end
         SCHED_DRAIN: begin
            id_ex_flush_c = 1'b1;
            if (drain_cnt == '0) begin
               state_nx  = SCHED_HALT;
               halted_nx = 1'b1;
            end else begin
               drain_nx = drain_cnt - DW'(1);
            end
         end
         SCHED_HALT: begin
            id_ex_flush_c = 1'b1;
            if (resume) begin
               state_nx  = SCHED_RUN;
               halted_nx = 1'b0;
            end
         end
         default: begin
            state_nx  = SCHED_RUN;
            halted_nx = 1'b0;
         end
      endcase
   end

   assign pc_en       = en & pc_en_c;
   assign if_id_en    = en & if_id_en_c;
   assign if_id_flush = en & if_id_flush_c;
   assign id_ex_flush = en & id_ex_flush_c;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .inc (stall_inc),
      .cnt (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .inc (flush_inc),
      .cnt (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_sched.sv
// tb/tb_pipe_sched.sv - directed self-checking bench for pipe_sched
module tb_pipe_sched;

   localparam int DRAIN_CYCLES = 3;
   localparam int CNT_W        = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [4:0]       id_rs, id_rt, ex_req_w;
   logic             id_uses_rs, id_uses_rt;
   logic             ex_rf_we, ex_is_load, ex_redirect, ex_halt, resume;
   logic             pc_en, if_id_en, if_id_flush, id_ex_flush, halted;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_errors = 0;

   pipe_sched #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rs  (id_uses_rs),
      .id_uses_rt  (id_uses_rt),
      .ex_rf_we    (ex_rf_we),
      .ex_req_w    (ex_req_w),
      .ex_is_load  (ex_is_load),
      .ex_redirect (ex_redirect),
      .ex_halt     (ex_halt),
      .resume      (resume),
      .pc_en       (pc_en),
      .if_id_en    (if_id_en),
      .if_id_flush (if_id_flush),
      .id_ex_flush (id_ex_flush),
      .halted      (halted),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Check the four stage controls as one packed value {pc_en,if_id_en,if_id_flush,id_ex_flush}.
   task automatic check_ctl(input string tag, input int exp);
      #1;
      check(tag, int'({pc_en, if_id_en, if_id_flush, id_ex_flush}), exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en = 1'b1; id_rs = 5'd0; id_rt = 5'd0; ex_req_w = 5'd0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_rf_we = 1'b0;
      ex_is_load = 1'b0; ex_redirect = 1'b0; ex_halt = 1'b0; resume = 1'b0;
   endtask

   task automatic load_use_rs(input logic [4:0] r);
      ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_req_w = r;
      id_uses_rs = 1'b1; id_rs = r;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      #12;
      check("reset_halted", int'(halted), 0);
      check("reset_stall", int'(stall_cnt), 0);
      check("reset_flush", int'(flush_cnt), 0);
      rst = 1'b0;
      tick();

      // Normal flow.
      check_ctl("run_idle", 4'b1100);

      // Load-use on rs: one bubble, then normal flow.
      load_use_rs(5'd8);
      check_ctl("lu_ctl", 4'b0001);
      tick();
      check("lu_stall_cnt", int'(stall_cnt), 1);
      idle();
      check_ctl("lu_after", 4'b1100);
      tick();

      // $0 destination never stalls.
      load_use_rs(5'd0);
      check_ctl("r0_nostall", 4'b1100);
      tick();
      // Matching rt that is not read does not stall.
      idle();
      ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_req_w = 5'd5; id_rt = 5'd5;
      check_ctl("rt_unused", 4'b1100);
      tick();
      check("nostall_cnt", int'(stall_cnt), 1);
      // Load without register write does not stall.
      id_uses_rt = 1'b1; ex_rf_we = 1'b0;
      check_ctl("no_we", 4'b1100);
      tick();

      // Redirect beats hazard.
      idle();
      load_use_rs(5'd9);
      ex_redirect = 1'b1;
      check_ctl("redir_hz_ctl", 4'b1111);
      tick();
      check("redir_flush", int'(flush_cnt), 1);
      check("redir_stall", int'(stall_cnt), 1);

      // en=0 with a hazard: controls dead, nothing counted.
      idle();
      load_use_rs(5'd7);
      en = 1'b0;
      check_ctl("en0_ctl", 4'b0000);
      tick();
      check("en0_stall", int'(stall_cnt), 1);

      // Halt sequence, cycle t: ex_halt beats redirect and hazard.
      idle();
      load_use_rs(5'd7);
      ex_redirect = 1'b1;
      ex_halt = 1'b1;
      check_ctl("halt_t", 4'b0111);
      tick();
      check("halt_noflush", int'(flush_cnt), 1);
      check("halt_nostall", int'(stall_cnt), 1);
      idle();                                  // t+1
      ex_redirect = 1'b1;
      check_ctl("drain_t1", 4'b0001);
      check("drain_t1_halted", int'(halted), 0);
      tick();
      idle();                                  // t+2: resume ignored
      resume = 1'b1;
      check_ctl("drain_t2", 4'b0001);
      tick();
      check("drain_t3_halted", int'(halted), 0); // t+3, resume still ignored
      check_ctl("drain_t3", 4'b0001);
      tick();
      resume = 1'b0;                           // t+4
      check("halt_t4_halted", int'(halted), 1);
      check_ctl("halt_t4", 4'b0001);
      tick();
      resume = 1'b1;                           // t+5
      tick();
      resume = 1'b0;                           // t+6
      check("resume_halted", int'(halted), 0);
      check_ctl("resume_ctl", 4'b1100);
      tick();

      // Halt with two en=0 cycles inside DRAIN.
      ex_halt = 1'b1;                          // t
      tick();
      ex_halt = 1'b0;
      en = 1'b0;                               // t+1
      tick();
      tick();                                  // t+2
      en = 1'b1;                               // t+3
      tick();
      check("en0_drain_t4", int'(halted), 0);  // t+4
      tick();
      check("en0_drain_t5", int'(halted), 0);  // t+5
      tick();
      check("en0_drain_t6", int'(halted), 1);
      check("en0_drain_stall", int'(stall_cnt), 1);
      check("en0_drain_flush", int'(flush_cnt), 1);

      // Async reset in HALT, away from any edge.
      #2;
      rst = 1'b1;
      #1;
      check("arst_halted", int'(halted), 0);
      check("arst_stall", int'(stall_cnt), 0);
      check("arst_flush", int'(flush_cnt), 0);
      #2;
      rst = 1'b0;
      tick();
      check_ctl("arst_run", 4'b1100);

      // Saturation: continuous hazard.
      load_use_rs(5'd3);
      for (int i = 0; i < 14; i++) tick();
      check("sat_14", int'(stall_cnt), 14);
      tick();
      check("sat_15", int'(stall_cnt), 15);
      for (int i = 0; i < 3; i++) tick();
      check("sat_hold", int'(stall_cnt), 15);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
